// File: rtl/aska_deadtime_pkg.sv
// Shared ASKA definitions: FSM state encodings, default bridge size and dead time.
package aska_deadtime_pkg;

  localparam int ASKA_NSW      = 32;
  localparam int ASKA_DEADTIME = 2;
  localparam int DT_W          = 4;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2,
    ST_FAULT = 2'd3
  } dt_state_t;

endpackage

// File: rtl/aska_dt_timer.sv
// Dead-time down-counter: load restarts the interval, clr abandons it,
// otherwise it counts down to zero and parks there.
module aska_dt_timer
  import aska_deadtime_pkg::*;
#(
  parameter int DEADTIME = ASKA_DEADTIME
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic clr,
  output logic last,
  output logic zero
);

  logic [DT_W-1:0] cnt;

  // Interval counter; load wins over clr so a reload inside BREAK restarts it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= DT_W'(DEADTIME);
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - DT_W'(1);
    end
  end

  // last: this edge is the final one of the interval.
  assign last = (cnt == DT_W'(1));
  assign zero = (cnt == '0);

endmodule

// File: rtl/aska_deadtime.sv
// Break-before-make guard between the pulse generator and the H-bridge
// switches: turn-offs pass straight through, turn-ons wait out a dead time,
// and any P/N overlap request latches the bridge into FAULT.
module aska_deadtime
  import aska_deadtime_pkg::*;
#(
  parameter int NSW      = ASKA_NSW,
  parameter int DEADTIME = ASKA_DEADTIME
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           enable,
  input  logic [NSW-1:0] up_in,
  input  logic [NSW-1:0] down_in,
  input  logic [5:0]     dac_in,
  input  logic           pulse_active_in,
  input  logic           fault_clr,
  output logic [NSW-1:0] up_out,
  output logic [NSW-1:0] down_out,
  output logic [5:0]     dac_out,
  output logic           pulse_active_out,
  output logic           busy,
  output logic           fault
);

  dt_state_t      state, state_nxt;
  logic [NSW-1:0] app_up, app_dn, app_up_nxt, app_dn_nxt;
  logic [NSW-1:0] req_up, req_dn, req_up_nxt, req_dn_nxt;
  logic [NSW-1:0] up_p1, dn_p1, up_nxt, dn_nxt;
  logic [5:0]     dac_p1, dac_nxt;
  logic           vld_p1, vld_nxt;
  logic           busy_p1, fault_p1;
  logic           ovl, subset, req_chg;
  logic           tmr_load, tmr_clr, tmr_last, tmr_zero;

  aska_dt_timer #(.DEADTIME(DEADTIME)) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (tmr_load),
    .clr    (tmr_clr),
    .last   (tmr_last),
    .zero   (tmr_zero)
  );

  // Next state, next applied pattern and next registered outputs.
  always_comb begin
    state_nxt  = state;
    app_up_nxt = app_up;
    app_dn_nxt = app_dn;
    req_up_nxt = req_up;
    req_dn_nxt = req_dn;
    up_nxt     = '0;
    dn_nxt     = '0;
    dac_nxt    = '0;
    vld_nxt    = 1'b0;
    tmr_load   = 1'b0;
    ovl        = |(up_in & down_in);
    subset     = ((up_in & ~app_up) == '0) && ((down_in & ~app_dn) == '0);
    req_chg    = (up_in != req_up) || (down_in != req_dn);

    if (state != ST_OFF && ovl) begin
      state_nxt  = ST_FAULT;
      app_up_nxt = '0;
      app_dn_nxt = '0;
    end else begin
      case (state)
        ST_OFF: begin
          app_up_nxt = '0;
          app_dn_nxt = '0;
          if (enable) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            state_nxt  = ST_OFF;
            app_up_nxt = '0;
            app_dn_nxt = '0;
          end else if (subset) begin
            // Unchanged or turn-off only: safe to apply at once.
            app_up_nxt = up_in;
            app_dn_nxt = down_in;
            up_nxt     = up_in;
            dn_nxt     = down_in;
            dac_nxt    = dac_in;
            vld_nxt    = pulse_active_in;
          end else begin
            // Turn-on requested: drop everything not kept, then wait.
            state_nxt  = ST_BREAK;
            app_up_nxt = app_up & up_in;
            app_dn_nxt = app_dn & down_in;
            up_nxt     = app_up & up_in;
            dn_nxt     = app_dn & down_in;
            vld_nxt    = vld_p1;
            req_up_nxt = up_in;
            req_dn_nxt = down_in;
            tmr_load   = 1'b1;
          end
        end
        ST_BREAK: begin
          if (!enable) begin
            state_nxt  = ST_OFF;
            app_up_nxt = '0;
            app_dn_nxt = '0;
          end else if (req_chg) begin
            // Request moved again: only ever narrow the bridge, restart wait.
            app_up_nxt = app_up & up_in;
            app_dn_nxt = app_dn & down_in;
            up_nxt     = app_up & up_in;
            dn_nxt     = app_dn & down_in;
            vld_nxt    = vld_p1;
            req_up_nxt = up_in;
            req_dn_nxt = down_in;
            tmr_load   = 1'b1;
          end else if (tmr_last || tmr_zero) begin
            state_nxt  = ST_RUN;
            app_up_nxt = up_in;
            app_dn_nxt = down_in;
            up_nxt     = up_in;
            dn_nxt     = down_in;
            dac_nxt    = dac_in;
            vld_nxt    = pulse_active_in;
          end else begin
            up_nxt  = app_up;
            dn_nxt  = app_dn;
            vld_nxt = vld_p1;
          end
        end
        ST_FAULT: begin
          app_up_nxt = '0;
          app_dn_nxt = '0;
          if (fault_clr) state_nxt = ST_OFF;
        end
        default: begin
          state_nxt  = ST_OFF;
          app_up_nxt = '0;
          app_dn_nxt = '0;
        end
      endcase
    end

    tmr_clr = (state_nxt != ST_BREAK);
  end

  // State, applied/requested patterns and the output stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_OFF;
      app_up   <= '0;
      app_dn   <= '0;
      req_up   <= '0;
      req_dn   <= '0;
      up_p1    <= '0;
      dn_p1    <= '0;
      dac_p1   <= '0;
      vld_p1   <= 1'b0;
      busy_p1  <= 1'b0;
      fault_p1 <= 1'b0;
    end else begin
      state    <= state_nxt;
      app_up   <= app_up_nxt;
      app_dn   <= app_dn_nxt;
      req_up   <= req_up_nxt;
      req_dn   <= req_dn_nxt;
      up_p1    <= up_nxt;
      dn_p1    <= dn_nxt;
      dac_p1   <= dac_nxt;
      vld_p1   <= vld_nxt;
      busy_p1  <= (state_nxt == ST_BREAK);
      fault_p1 <= (state_nxt == ST_FAULT);
    end
  end

  assign up_out           = up_p1;
  assign down_out         = dn_p1;
  assign dac_out          = dac_p1;
  assign pulse_active_out = vld_p1;
  assign busy             = busy_p1;
  assign fault            = fault_p1;

endmodule

// File: tb/tb_aska_deadtime.sv
// Directed bench for aska_deadtime with DEADTIME=2, NSW=32.
module tb_aska_deadtime;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [31:0] up_in, down_in;
  logic [5:0]  dac_in;
  logic        pulse_active_in;
  logic        fault_clr;
  logic [31:0] up_out, down_out;
  logic [5:0]  dac_out;
  logic        pulse_active_out, busy, fault;

  int n_assert = 0;
  int n_fail   = 0;

  aska_deadtime #(.NSW(32), .DEADTIME(2)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .enable           (enable),
    .up_in            (up_in),
    .down_in          (down_in),
    .dac_in           (dac_in),
    .pulse_active_in  (pulse_active_in),
    .fault_clr        (fault_clr),
    .up_out           (up_out),
    .down_out         (down_out),
    .dac_out          (dac_out),
    .pulse_active_out (pulse_active_out),
    .busy             (busy),
    .fault            (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] eu, input logic [31:0] ed,
                     input logic [5:0] ea, input logic ep, input logic eb, input logic ef);
    logic [72:0] obs_v, exp_v;
    obs_v = {up_out, down_out, dac_out, pulse_active_out, busy, fault};
    exp_v = {eu, ed, ea, ep, eb, ef};
    n_assert++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed up=%h dn=%h dac=%0d pa=%b busy=%b fault=%b, expected up=%h dn=%h dac=%0d pa=%b busy=%b fault=%b",
             tag, up_out, down_out, dac_out, pulse_active_out, busy, fault, eu, ed, ea, ep, eb, ef);
    end
  endtask

  task automatic drive(input logic [31:0] u, input logic [31:0] d);
    up_in   = u;
    down_in = d;
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; up_in = '0; down_in = '0;
    dac_in = 6'd0; pulse_active_in = 1'b0; fault_clr = 1'b0;
    #3;
    chk("reset_state", 32'h0, 32'h0, 6'd0, 0, 0, 0);
    #14 resetn = 1'b1;
    tick();
    chk("off_idle", 32'h0, 32'h0, 6'd0, 0, 0, 0);

    // Enable with zero pattern: RUN, nothing driven
    enable = 1'b1;
    tick();
    chk("run_zero", 32'h0, 32'h0, 6'd0, 0, 0, 0);

    // First turn-on from zero pattern goes through the dead time
    drive(32'h1, 32'h2); dac_in = 6'd20; pulse_active_in = 1'b1;
    tick(); chk("on_c1", 32'h0, 32'h0, 6'd0, 0, 1, 0);
    tick(); chk("on_c2", 32'h0, 32'h0, 6'd0, 0, 1, 0);
    tick(); chk("on_c3", 32'h1, 32'h2, 6'd20, 1, 0, 0);

    // Same pattern: DAC tracks with one-cycle latency
    dac_in = 6'd33;
    tick(); chk("dac_track", 32'h1, 32'h2, 6'd33, 1, 0, 0);

    // Swap polarity: full break, then swapped pattern
    drive(32'h2, 32'h1);
    tick(); chk("swap_c1", 32'h0, 32'h0, 6'd0, 1, 1, 0);
    tick(); chk("swap_c2", 32'h0, 32'h0, 6'd0, 1, 1, 0);
    tick(); chk("swap_c3", 32'h2, 32'h1, 6'd33, 1, 0, 0);

    // To up=3: bit 1 of up is kept during the break
    drive(32'h3, 32'h0);
    tick(); chk("to3_c1", 32'h2, 32'h0, 6'd0, 1, 1, 0);
    tick(); chk("to3_c2", 32'h2, 32'h0, 6'd0, 1, 1, 0);
    tick(); chk("to3_c3", 32'h3, 32'h0, 6'd33, 1, 0, 0);

    // Clearing only: applied next cycle, no busy
    drive(32'h1, 32'h0);
    tick(); chk("clear_c1", 32'h1, 32'h0, 6'd33, 1, 0, 0);
    tick(); chk("clear_c2", 32'h1, 32'h0, 6'd33, 1, 0, 0);

    // Overlap -> FAULT; clear refused while overlap persists or without fault_clr
    drive(32'h4, 32'h4);
    tick(); chk("fault_in", 32'h0, 32'h0, 6'd0, 0, 0, 1);
    fault_clr = 1'b1;
    tick(); chk("fault_hold_ovl", 32'h0, 32'h0, 6'd0, 0, 0, 1);
    fault_clr = 1'b0; enable = 1'b0; drive(32'h0, 32'h0);
    tick(); chk("fault_hold_en0", 32'h0, 32'h0, 6'd0, 0, 0, 1);
    fault_clr = 1'b1;
    tick(); chk("fault_clear", 32'h0, 32'h0, 6'd0, 0, 0, 0);
    fault_clr = 1'b0; enable = 1'b1;
    tick(); chk("rerun", 32'h0, 32'h0, 6'd0, 0, 0, 0);

    // Establish F0/0F
    drive(32'hF0, 32'h0F);
    tick(); chk("est_c1", 32'h0, 32'h0, 6'd0, 0, 1, 0);
    tick(); chk("est_c2", 32'h0, 32'h0, 6'd0, 0, 1, 0);
    tick(); chk("est_c3", 32'hF0, 32'h0F, 6'd33, 1, 0, 0);

    // Burst of pattern changes: outputs only narrow, busy stays high
    drive(32'h70, 32'h10F);
    tick(); chk("burst0", 32'h70, 32'h0F, 6'd0, 1, 1, 0);
    drive(32'h30, 32'h20E);
    tick(); chk("burst1", 32'h30, 32'h0E, 6'd0, 1, 1, 0);
    drive(32'h3C, 32'h02);
    tick(); chk("burst2", 32'h30, 32'h02, 6'd0, 1, 1, 0);
    drive(32'h11, 32'h02);
    tick(); chk("burst3", 32'h10, 32'h02, 6'd0, 1, 1, 0);
    drive(32'h31, 32'h42);
    tick(); chk("burst4", 32'h10, 32'h02, 6'd0, 1, 1, 0);
    tick(); chk("burst_wait", 32'h10, 32'h02, 6'd0, 1, 1, 0);
    tick(); chk("burst_apply", 32'h31, 32'h42, 6'd33, 1, 0, 0);

    // Async reset in the middle of a break
    drive(32'h31, 32'h842);
    tick(); chk("pre_rst_break", 32'h31, 32'h42, 6'd0, 1, 1, 0);
    #2 resetn = 1'b0;
    #1 chk("async_rst", 32'h0, 32'h0, 6'd0, 0, 0, 0);
    #3 resetn = 1'b1;
    tick(); chk("post_rst", 32'h0, 32'h0, 6'd0, 0, 0, 0);
    tick(); chk("post_rst_brk1", 32'h0, 32'h0, 6'd0, 0, 1, 0);
    tick(); chk("post_rst_brk2", 32'h0, 32'h0, 6'd0, 0, 1, 0);
    tick(); chk("post_rst_apply", 32'h31, 32'h842, 6'd33, 1, 0, 0);

    // Disable in RUN
    enable = 1'b0;
    tick(); chk("disable", 32'h0, 32'h0, 6'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aska_deadtime.md
ASKA_DEADTIME -- requirements
Module: aska_deadtime

Interface
REQ-001 SHALL have parameter NSW, default 32, number of H-bridge switch pairs.
REQ-002 SHALL have parameter DEADTIME, default 2, break-before-make interval in clk cycles (legal 1..15).
REQ-003 SHALL have port clk input 1: system clock, all state updates on rising edge.
REQ-004 SHALL have port resetn input 1: reset, asynchronous, active-low.
REQ-005 SHALL have port enable input 1: stimulation enable; low forces all outputs off.
REQ-006 SHALL have port up_in input NSW: requested P-switch pattern.
REQ-007 SHALL have port down_in input NSW: requested N-switch pattern.
REQ-008 SHALL have port dac_in input 6: requested DAC amplitude code.
REQ-009 SHALL have port pulse_active_in input 1: pulse-in-progress flag from the pulse generator.
REQ-010 SHALL have port fault_clr input 1: level request to leave FAULT.
REQ-011 SHALL have port up_out output NSW: P-switch drive to the bridge.
REQ-012 SHALL have port down_out output NSW: N-switch drive to the bridge.
REQ-013 SHALL have port dac_out output 6: DAC code to the current source.
REQ-014 SHALL have port pulse_active_out output 1: pulse flag aligned with applied pattern.
REQ-015 SHALL have port busy output 1: high while a dead-time interval is running.
REQ-016 SHALL have port fault output 1: high while in FAULT.

Function
REQ-017 SHALL register all outputs; every output change SHALL appear one clk after the triggering input sample.
REQ-018 SHALL implement FSM states OFF, RUN, BREAK, FAULT.
REQ-019 In OFF, outputs SHALL be zero; enable=1 SHALL move to RUN with outputs still zero (applied pattern = 0).
REQ-020 In RUN, if {up_in,down_in} equals applied pattern, outputs and dac_out SHALL track dac_in/pulse_active_in with 1-cycle latency.
REQ-021 In RUN, a change that only clears bits (new pattern subset of applied) SHALL be applied next cycle with no dead time.
REQ-022 In RUN, a change that sets any bit SHALL go to BREAK: outputs = applied AND new, dac_out = 0, counter loaded with DEADTIME.
REQ-023 In BREAK, counter SHALL decrement each cycle; when it reaches 0 the FSM SHALL apply the current input pattern and dac_in and return to RUN, so new turn-ons appear DEADTIME+1 cycles after the input change.
REQ-024 Any further pattern change during BREAK SHALL further clear outputs (AND with new) and reload counter with DEADTIME.
REQ-025 busy SHALL be 1 exactly in BREAK.
REQ-026 pulse_active_out SHALL be pulse_active_in delayed one cycle in RUN, forced 0 in OFF/FAULT, held at its value in BREAK.
REQ-027 Any sample with (up_in AND down_in) != 0 SHALL, from any state except OFF, enter FAULT next cycle with all switch outputs, dac_out, pulse_active_out = 0 and fault = 1; this takes priority over all other transitions except reset.
REQ-028 FAULT SHALL persist until fault_clr=1 and (up_in AND down_in)=0 in the same cycle, then go to OFF.
REQ-029 enable=0 SHALL move RUN/BREAK to OFF next cycle with all outputs zero; enable SHALL NOT clear FAULT.
REQ-030 On leaving OFF to RUN, first non-zero pattern SHALL pass through BREAK (rule REQ-022 applies from the zero pattern).

Reset
REQ-031 resetn=0 SHALL asynchronously force state OFF, counter 0, applied pattern 0, and every output 0.
REQ-032 Reset asserted mid-BREAK or mid-FAULT SHALL behave identically to REQ-031; release SHALL resume from OFF on the next edge.

Structure
REQ-033 State encodings, NSW and DEADTIME default SHALL live in the shared ASKA definitions include.
REQ-034 The dead-time down-counter with load/zero flag SHALL be a sub-module aska_dt_timer; the FSM and pattern registers SHALL stay in aska_deadtime.

Verification
REQ-035 Reset, enable=1, up_in=0x1, down_in=0x2, dac_in=20 -> outputs 0 for cycles 1..2 (busy=1), up_out=0x1/down_out=0x2/dac_out=20 on cycle 3 (DEADTIME=2).
REQ-036 From applied up=0x1/down=0x2, inputs -> up=0x2/down=0x1 -> next cycle all off, dac_out=0, busy=1; swapped pattern applied DEADTIME+1 cycles after change.
REQ-037 From up=0x3/down=0x0, inputs -> up=0x1 -> up_out=0x1 next cycle, busy never asserted.
REQ-038 up_in=0x4, down_in=0x4 during RUN -> next cycle fault=1, all outputs 0; fault_clr=1 with legal inputs -> OFF; fault_clr=1 with overlap still present -> remain FAULT.
REQ-039 Pattern change every cycle for 5 cycles during BREAK -> busy stays 1, no output bit ever set that was not set before the burst; apply DEADTIME+1 cycles after last change.
REQ-040 resetn pulsed low mid-BREAK (asynchronous to clk edge) -> outputs 0 immediately, state OFF after release; enable=0 in RUN -> outputs 0 next cycle.
